vx_ti_mem_sched: RTL and testbench

Request scheduler for the traversal/intersection (TI) unit's memory port. It arbitrates NUM_REQS traversal requesters onto one cache request channel using round-robin priority. Each in-flight request is tracked in a pending table that maps a slot ID to the originating requester and tag. Memory responses are routed back to that requester by slot ID. It sits between the TI traversal lanes and one lane of the RCACHE memory bus.

---
 rtl/vx_ti_mem_sched.sv | 183 ++++++++++++++++++
 tb/tb_vx_ti_mem_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_ti_mem_sched.sv
// Round-robin request scheduler for the TI memory port: tracks in-flight requests in a
// pending table and routes each response back to its requester by slot ID.
module vx_ti_mem_sched #(
   parameter int NUM_REQS     = 4,
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 64,
   parameter int TAG_WIDTH    = 8,
   parameter int MAX_PENDING  = 8,
   localparam int PTAG_WIDTH  = $clog2(MAX_PENDING)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_REQS-1:0]                  req_valid,
   input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   req_tag,
   output logic [NUM_REQS-1:0]                  req_ready,
   output logic                                 mem_req_valid,
   output logic [ADDR_WIDTH-1:0]                mem_req_addr,
   output logic [PTAG_WIDTH-1:0]                mem_req_tag,
   input  logic                                 mem_req_ready,
   input  logic                                 mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]                mem_rsp_data,
   input  logic [PTAG_WIDTH-1:0]                mem_rsp_tag,
   output logic                                 mem_rsp_ready,
   output logic [NUM_REQS-1:0]                  rsp_valid,
   output logic [DATA_WIDTH-1:0]                rsp_data,
   output logic [TAG_WIDTH-1:0]                 rsp_tag,
   input  logic [NUM_REQS-1:0]                  rsp_ready,
   output logic [PTAG_WIDTH:0]                  pending_count,
   output logic                                 stray_rsp
);

   localparam int RR_WIDTH = $clog2(NUM_REQS);

   logic [MAX_PENDING-1:0] slot_valid_r;
   logic [RR_WIDTH-1:0]    slot_owner_r [MAX_PENDING];
   logic [TAG_WIDTH-1:0]   slot_tag_r   [MAX_PENDING];

   logic                   out_valid_r;
   logic [ADDR_WIDTH-1:0]  out_addr_r;
   logic [PTAG_WIDTH-1:0]  out_slot_r;
   logic [RR_WIDTH-1:0]    rr_ptr_r;
   logic [PTAG_WIDTH:0]    count_r;
   logic                   stray_r;

   logic                   free_found_s;
   logic [PTAG_WIDTH-1:0]  free_slot_s;
   logic                   grant_found_s;
   logic [RR_WIDTH-1:0]    grant_idx_s;
   logic                   can_load_s;
   logic                   grant_s;
   logic [RR_WIDTH-1:0]    owner_s;
   logic                   slot_hit_s;
   logic                   free_s;
   logic [MAX_PENDING-1:0] alloc_mask_s;
   logic [MAX_PENDING-1:0] free_mask_s;

   // Lowest-index free slot, searched over the pre-free mask.
   always_comb begin
      free_found_s = 1'b0;
      free_slot_s  = '0;
      for (int i = 0; i < MAX_PENDING; i++) begin
         if (!free_found_s && !slot_valid_r[PTAG_WIDTH'(i)]) begin
            free_found_s = 1'b1;
            free_slot_s  = PTAG_WIDTH'(i);
         end else begin
            free_found_s = free_found_s;
         end
      end
   end

   // Round-robin search starting at rr_ptr.
   always_comb begin : arb_search
      int cand;
      cand          = 0;
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      for (int k = 0; k < NUM_REQS; k++) begin
         cand = (int'(rr_ptr_r) + k) % NUM_REQS;
         if (!grant_found_s && req_valid[RR_WIDTH'(cand)]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = RR_WIDTH'(cand);
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   assign can_load_s = (~out_valid_r | mem_req_ready) & free_found_s & ~reset;
   assign grant_s    = can_load_s & grant_found_s;

   // One-hot accept strobe toward the granted requester.
   always_comb begin
      req_ready = '0;
      if (grant_s) begin
         req_ready[grant_idx_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   assign owner_s    = slot_owner_r[mem_rsp_tag];
   assign slot_hit_s = slot_valid_r[mem_rsp_tag];
   assign rsp_data   = mem_rsp_data;
   assign rsp_tag    = slot_tag_r[mem_rsp_tag];

   // Response routing; responses to empty slots are swallowed.
   always_comb begin
      rsp_valid     = '0;
      mem_rsp_ready = 1'b0;
      if (reset) begin
         mem_rsp_ready = 1'b0;
      end else if (slot_hit_s) begin
         rsp_valid[owner_s] = mem_rsp_valid;
         mem_rsp_ready      = rsp_ready[owner_s];
      end else begin
         mem_rsp_ready = mem_rsp_valid;
      end
   end

   assign free_s       = mem_rsp_valid & slot_hit_s & rsp_ready[owner_s] & ~reset;
   assign alloc_mask_s = grant_s ? (MAX_PENDING'(1) << free_slot_s) : '0;
   assign free_mask_s  = free_s  ? (MAX_PENDING'(1) << mem_rsp_tag) : '0;

   // Pending table: allocation and release never target the same slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_valid_r <= '0;
         for (int i = 0; i < MAX_PENDING; i++) begin
            slot_owner_r[i] <= '0;
            slot_tag_r[i]   <= '0;
         end
      end else begin
         slot_valid_r <= (slot_valid_r & ~free_mask_s) | alloc_mask_s;
         for (int i = 0; i < MAX_PENDING; i++) begin
            if (alloc_mask_s[PTAG_WIDTH'(i)]) begin
               slot_owner_r[i] <= grant_idx_s;
               slot_tag_r[i]   <= req_tag[grant_idx_s];
            end else begin
               slot_owner_r[i] <= slot_owner_r[i];
               slot_tag_r[i]   <= slot_tag_r[i];
            end
         end
      end
   end

   // Output request register and round-robin pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_addr_r  <= '0;
         out_slot_r  <= '0;
         rr_ptr_r    <= '0;
      end else if (grant_s) begin
         out_valid_r <= 1'b1;
         out_addr_r  <= req_addr[grant_idx_s];
         out_slot_r  <= free_slot_s;
         rr_ptr_r    <= (int'(grant_idx_s) == NUM_REQS - 1) ? '0 : grant_idx_s + RR_WIDTH'(1);
      end else if (mem_req_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   // Occupancy counter and stray-response pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r <= '0;
         stray_r <= 1'b0;
      end else begin
         count_r <= count_r + (PTAG_WIDTH+1)'(grant_s) - (PTAG_WIDTH+1)'(free_s);
         stray_r <= mem_rsp_valid & ~slot_hit_s;
      end
   end

   assign mem_req_valid = out_valid_r;
   assign mem_req_addr  = out_addr_r;
   assign mem_req_tag   = out_slot_r;
   assign pending_count = count_r;
   assign stray_rsp     = stray_r;

endmodule

// File: tb/tb_vx_ti_mem_sched.sv
// Bench for vx_ti_mem_sched: directed vector table, hand-written corner sequences and a
// randomized run against a slot-table reference model.
module tb_vx_ti_mem_sched;
   localparam int N = 4, AW = 32, DW = 64, TW = 8, MP = 8, PW = 3;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [N-1:0]        req_valid;
   logic [N-1:0][AW-1:0] req_addr;
   logic [N-1:0][TW-1:0] req_tag;
   logic [N-1:0]        req_ready;
   logic                mem_req_valid;
   logic [AW-1:0]       mem_req_addr;
   logic [PW-1:0]       mem_req_tag;
   logic                mem_req_ready;
   logic                mem_rsp_valid;
   logic [DW-1:0]       mem_rsp_data;
   logic [PW-1:0]       mem_rsp_tag;
   logic                mem_rsp_ready;
   logic [N-1:0]        rsp_valid;
   logic [DW-1:0]       rsp_data;
   logic [TW-1:0]       rsp_tag;
   logic [N-1:0]        rsp_ready;
   logic [PW:0]         pending_count;
   logic                stray_rsp;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vx_ti_mem_sched #(.NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
                     .MAX_PENDING(MP)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_addr(req_addr), .req_tag(req_tag), .req_ready(req_ready),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
      .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
      .mem_rsp_ready(mem_rsp_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
      .pending_count(pending_count), .stray_rsp(stray_rsp)
   );

   typedef struct {
      logic [3:0]  rv;
      logic        mrr;
      logic        mrv;
      logic [2:0]  mtag;
      logic [3:0]  rr;
      logic [3:0]  e_req_ready;
      logic        e_mvalid;
      logic [2:0]  e_mtag;
      logic [31:0] e_maddr;
      logic [3:0]  e_rsp_valid;
      logic [7:0]  e_rsp_tag;
      logic        e_mrsp_ready;
      logic [3:0]  e_pend;
      logic        e_stray;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid     = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_tag   = '0;
      rsp_ready     = '0;
   endtask

   task automatic set_fixed();
      for (int i = 0; i < N; i++) begin
         req_addr[i] = (i == 2) ? 32'h1000 : 32'(32'h2000 + i);
         req_tag[i]  = (i == 2) ? 8'h5A : 8'(8'h10 + i);
      end
      mem_rsp_data = 64'hDEAD;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic run_table();
      vecs[0]  = '{4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b0, 3'd0, 32'h0,    4'b0000, 8'h00, 1'b0, 4'd0, 1'b0};
      vecs[1]  = '{4'b0100, 1'b1, 1'b0, 3'd0, 4'b0000, 4'b0100, 1'b0, 3'd0, 32'h0,    4'b0000, 8'h00, 1'b0, 4'd0, 1'b0};
      vecs[2]  = '{4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b1, 3'd0, 32'h1000, 4'b0000, 8'h00, 1'b0, 4'd1, 1'b0};
      vecs[3]  = '{4'b0000, 1'b1, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b1, 3'd0, 32'h1000, 4'b0000, 8'h00, 1'b0, 4'd1, 1'b0};
      vecs[4]  = '{4'b0000, 1'b0, 1'b1, 3'd0, 4'b0100, 4'b0000, 1'b0, 3'd0, 32'h0,    4'b0100, 8'h5A, 1'b1, 4'd1, 1'b0};
      vecs[5]  = '{4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b0, 3'd0, 32'h0,    4'b0000, 8'h00, 1'b0, 4'd0, 1'b0};
      vecs[6]  = '{4'b0000, 1'b0, 1'b1, 3'd5, 4'b1111, 4'b0000, 1'b0, 3'd0, 32'h0,    4'b0000, 8'h00, 1'b1, 4'd0, 1'b0};
      vecs[7]  = '{4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b0, 3'd0, 32'h0,    4'b0000, 8'h00, 1'b0, 4'd0, 1'b1};
      vecs[8]  = '{4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b0, 3'd0, 32'h0,    4'b0000, 8'h00, 1'b0, 4'd0, 1'b0};
      vecs[9]  = '{4'b1111, 1'b1, 1'b0, 3'd0, 4'b0000, 4'b1000, 1'b0, 3'd0, 32'h0,    4'b0000, 8'h00, 1'b0, 4'd0, 1'b0};
      vecs[10] = '{4'b1111, 1'b1, 1'b0, 3'd0, 4'b0000, 4'b0001, 1'b1, 3'd0, 32'h2003, 4'b0000, 8'h00, 1'b0, 4'd1, 1'b0};
      vecs[11] = '{4'b0000, 1'b1, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b1, 3'd1, 32'h2000, 4'b0000, 8'h00, 1'b0, 4'd2, 1'b0};
      vecs[12] = '{4'b0000, 1'b0, 1'b1, 3'd1, 4'b0000, 4'b0000, 1'b0, 3'd0, 32'h0,    4'b0001, 8'h10, 1'b0, 4'd2, 1'b0};
      vecs[13] = '{4'b0000, 1'b0, 1'b1, 3'd1, 4'b0001, 4'b0000, 1'b0, 3'd0, 32'h0,    4'b0001, 8'h10, 1'b1, 4'd2, 1'b0};
      vecs[14] = '{4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b0, 3'd0, 32'h0,    4'b0000, 8'h00, 1'b0, 4'd1, 1'b0};
      for (int v = 0; v < 15; v++) begin
         req_valid     = vecs[v].rv;
         mem_req_ready = vecs[v].mrr;
         mem_rsp_valid = vecs[v].mrv;
         mem_rsp_tag   = vecs[v].mtag;
         rsp_ready     = vecs[v].rr;
         #1;
         chk($sformatf("vec%0d req_ready", v), req_ready, vecs[v].e_req_ready);
         chk($sformatf("vec%0d mem_req_valid", v), mem_req_valid, vecs[v].e_mvalid);
         if (vecs[v].e_mvalid) begin
            chk($sformatf("vec%0d mem_req_tag", v), mem_req_tag, vecs[v].e_mtag);
            chk($sformatf("vec%0d mem_req_addr", v), mem_req_addr, vecs[v].e_maddr);
         end
         chk($sformatf("vec%0d rsp_valid", v), rsp_valid, vecs[v].e_rsp_valid);
         if (vecs[v].e_rsp_valid != 4'b0000) begin
            chk($sformatf("vec%0d rsp_tag", v), rsp_tag, vecs[v].e_rsp_tag);
            chk($sformatf("vec%0d rsp_data", v), rsp_data, 64'hDEAD);
         end
         chk($sformatf("vec%0d mem_rsp_ready", v), mem_rsp_ready, vecs[v].e_mrsp_ready);
         chk($sformatf("vec%0d pending_count", v), pending_count, vecs[v].e_pend);
         chk($sformatf("vec%0d stray_rsp", v), stray_rsp, vecs[v].e_stray);
         next_cycle();
      end
   endtask

   task automatic run_fill_and_free();
      do_reset();
      set_fixed();
      req_valid     = 4'b1111;
      mem_req_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("rr_grant", req_ready, 4'b0001 << (k % 4));
         chk("rr_pending", pending_count, k);
         if (k > 0) chk("rr_slot", mem_req_tag, k - 1);
         next_cycle();
      end
      #1;
      chk("full_no_grant", req_ready, 4'b0000);
      chk("full_pending", pending_count, 8);
      chk("full_last_slot", mem_req_tag, 7);
      next_cycle();
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = 3'd3;
      rsp_ready     = 4'b1111;
      #1;
      chk("free_same_cycle_no_grant", req_ready, 4'b0000);
      chk("free_rsp_valid", rsp_valid, 4'b1000);
      chk("free_rsp_tag", rsp_tag, 8'h13);
      chk("free_mem_rsp_ready", mem_rsp_ready, 1'b1);
      next_cycle();
      mem_rsp_tag = 3'd6;
      #1;
      chk("reuse_grant", req_ready, 4'b0001);
      chk("reuse_pending", pending_count, 7);
      chk("reuse_rsp_tag", rsp_tag, 8'h5A);
      next_cycle();
      mem_rsp_valid = 1'b0;
      #1;
      chk("reuse_slot3", mem_req_tag, 3);
      chk("alloc_free_pending", pending_count, 7);
      chk("reuse_grant2", req_ready, 4'b0010);
      next_cycle();
      #1;
      chk("reuse_slot6", mem_req_tag, 6);
      chk("refull_pending", pending_count, 8);
      chk("refull_no_grant", req_ready, 4'b0000);
   endtask

   task automatic run_backpressure_and_reset();
      do_reset();
      set_fixed();
      req_valid     = 4'b0001;
      mem_req_ready = 1'b0;
      #1;
      chk("bp_first_grant", req_ready, 4'b0001);
      next_cycle();
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_hold_valid", mem_req_valid, 1'b1);
         chk("bp_hold_tag", mem_req_tag, 0);
         chk("bp_hold_addr", mem_req_addr, 32'h2000);
         chk("bp_no_grant", req_ready, 4'b0000);
         next_cycle();
      end
      mem_req_ready = 1'b1;
      #1;
      chk("bp_release_grant", req_ready, 4'b0010);
      chk("bp_release_valid", mem_req_valid, 1'b1);
      next_cycle();
      #1;
      chk("bp_next_tag", mem_req_tag, 1);
      chk("bp_next_addr", mem_req_addr, 32'h2001);
      chk("bp_next_grant", req_ready, 4'b0100);
      next_cycle();
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = 3'd1;
      rsp_ready     = 4'b1111;
      #1;
      chk("pre_reset_pending", pending_count, 3);
      chk("pre_reset_grant", req_ready, 4'b1000);
      chk("pre_reset_rsp_valid", rsp_valid, 4'b0010);
      #1;
      reset = 1'b1;
      #1;
      chk("async_reset_req_ready", req_ready, 4'b0000);
      chk("async_reset_mem_req_valid", mem_req_valid, 1'b0);
      chk("async_reset_pending", pending_count, 0);
      chk("async_reset_rsp_valid", rsp_valid, 4'b0000);
      chk("async_reset_mem_rsp_ready", mem_rsp_ready, 1'b0);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      req_valid = 4'b0000;
      #1;
      chk("post_reset_stray_ready", mem_rsp_ready, 1'b1);
      chk("post_reset_stray_fwd", rsp_valid, 4'b0000);
      chk("post_reset_stray_early", stray_rsp, 1'b0);
      next_cycle();
      mem_rsp_valid = 1'b0;
      #1;
      chk("stray_pulse", stray_rsp, 1'b1);
      next_cycle();
      #1;
      chk("stray_pulse_end", stray_rsp, 1'b0);
   endtask

   task automatic run_random(input int ncyc);
      bit         mv [MP];
      logic [1:0] mo [MP];
      logic [7:0] mt [MP];
      bit         ov, st, can, hit;
      logic [31:0] oa;
      logic [2:0] os;
      int         rr, fslot, cnt, g, r, own;
      logic [3:0] e_rr, e_rv;
      logic       e_mrr;
      for (int i = 0; i < MP; i++) begin
         mv[i] = 1'b0; mo[i] = '0; mt[i] = '0;
      end
      ov = 1'b0; st = 1'b0; oa = '0; os = '0; rr = 0;
      do_reset();
      for (int c = 0; c < ncyc; c++) begin
         req_valid = 4'($urandom_range(0, 15));
         for (int i = 0; i < N; i++) begin
            req_addr[i] = $urandom;
            req_tag[i]  = 8'($urandom_range(0, 255));
         end
         mem_req_ready = ($urandom_range(0, 3) != 0);
         mem_rsp_valid = ($urandom_range(0, 99) < (((c / 400) % 2 == 1) ? 15 : 55));
         mem_rsp_tag   = 3'($urandom_range(0, 7));
         mem_rsp_data  = {$urandom, $urandom};
         rsp_ready     = 4'($urandom_range(0, 15));
         #1;
         fslot = -1;
         cnt   = 0;
         for (int i = 0; i < MP; i++) begin
            if (mv[i]) cnt++;
            else if (fslot < 0) fslot = i;
         end
         can = (!ov || mem_req_ready) && (fslot >= 0);
         g = -1;
         if (can) begin
            for (int j = 0; j < N; j++) begin
               r = (rr + j) % N;
               if (g < 0 && req_valid[r]) g = r;
            end
         end
         e_rr = '0;
         if (g >= 0) e_rr[g] = 1'b1;
         hit  = mv[mem_rsp_tag];
         own  = int'(mo[mem_rsp_tag]);
         e_rv = '0;
         if (mem_rsp_valid && hit) e_rv[own] = 1'b1;
         e_mrr = hit ? rsp_ready[own] : mem_rsp_valid;
         chk("rnd_req_ready", req_ready, e_rr);
         chk("rnd_mem_req_valid", mem_req_valid, ov);
         if (ov) begin
            chk("rnd_mem_req_tag", mem_req_tag, os);
            chk("rnd_mem_req_addr", mem_req_addr, oa);
         end
         chk("rnd_rsp_valid", rsp_valid, e_rv);
         if (e_rv != 4'b0000) begin
            chk("rnd_rsp_tag", rsp_tag, mt[mem_rsp_tag]);
            chk("rnd_rsp_data", rsp_data, mem_rsp_data);
         end
         chk("rnd_mem_rsp_ready", mem_rsp_ready, e_mrr);
         chk("rnd_pending", pending_count, cnt);
         chk("rnd_stray", stray_rsp, st);
         st = mem_rsp_valid && !hit;
         if (mem_rsp_valid && hit && rsp_ready[own]) mv[mem_rsp_tag] = 1'b0;
         if (g >= 0) begin
            mv[fslot] = 1'b1;
            mo[fslot] = 2'(g);
            mt[fslot] = req_tag[g];
            ov = 1'b1;
            oa = req_addr[g];
            os = 3'(fslot);
            rr = (g + 1) % N;
         end else if (mem_req_ready) begin
            ov = 1'b0;
         end
         next_cycle();
      end
   endtask

   initial begin
      idle_inputs();
      set_fixed();
      do_reset();
      set_fixed();
      run_table();
      run_fill_and_free();
      run_backpressure_and_reset();
      run_random(3000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
